decode_hazard: RTL

DECODE_HAZARD -- requirements
Module: decode_hazard

---
 rtl/decode_hazard_pkg.sv | 60 ++++++
 rtl/decode_hazard_fwd_sel.sv | 36 +++
 rtl/decode_hazard.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/decode_hazard_pkg.sv
// Shared definitions for the decode-stage hazard unit: FSM state type,
// operand-forwarding encodings, pipeline tracking records and the major
// opcode constants that the instruction decoder also uses.
package decode_hazard_pkg;

    // Hazard FSM: normal flow, or EX held by a multi-cycle multiply.
    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } hz_state_e;

    // Operand source selection driven to the EX operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Width of the multiply occupancy counter.
    localparam int unsigned MUL_CNT_W = 4;

    // Major opcodes shared with the decoder.
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    // What the instruction currently in EX will write, and how late.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       h0;
        logic       mul;
    } ex_trk_t;

    // What the instruction currently in MEM will write.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
    } mem_trk_t;

    // A pipeline slot produces src when it is live, writes, and targets
    // the same non-zero register (x0 is hard-wired and never forwarded).
    function automatic logic reg_hit(
        input logic       v,
        input logic       wr,
        input logic [4:0] rd,
        input logic [4:0] src
    );
        return v && wr && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/decode_hazard_fwd_sel.sv
// Per-operand comparator: picks the forwarding source for one ID source
// register and flags a dependency on a late (not yet available) EX result.
module hazard_fwd_sel
    import decode_hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ex_v,
    input  logic [4:0] ex_rd,
    input  logic       ex_wr,
    input  logic       ex_h0,
    input  logic       mem_v,
    input  logic [4:0] mem_rd,
    input  logic       mem_wr,
    output logic [1:0] fwd,
    output logic       ex_late_hit
);

    logic ex_hit_s;
    logic mem_hit_s;

    // Compare against EX then MEM; the younger EX result wins when usable.
    always_comb begin
        ex_hit_s    = reg_hit(ex_v, ex_wr, ex_rd, src);
        mem_hit_s   = reg_hit(mem_v, mem_wr, mem_rd, src);
        ex_late_hit = ex_hit_s & ex_h0;
        fwd         = FWD_RF;
        if (ex_hit_s && !ex_h0) begin
            fwd = FWD_EX;
        end else if (mem_hit_s) begin
            fwd = FWD_MEM;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/decode_hazard.sv
// Decode-stage hazard unit: load-use interlock, multi-cycle multiply
// occupancy of EX, redirect flush, and EX/MEM operand forwarding selects.
module decode_hazard
    import decode_hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_reg_write,
    input  logic       id_is_hazard_0,
    input  logic       id_is_multiply,
    input  logic       ex_redirect,
    output logic       stall,
    output logic       flush,
    output logic       ex_valid,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mul_busy
);

    // The multiply already occupies EX for the cycle it enters, so the
    // FSM holds for the remaining MUL_LAT-1 cycles.
    localparam logic [MUL_CNT_W-1:0] MUL_INIT = MUL_CNT_W'(MUL_LAT - 1);

    hz_state_e              state_r;
    hz_state_e              state_s;
    logic [MUL_CNT_W-1:0]   cnt_r;
    logic [MUL_CNT_W-1:0]   cnt_s;
    ex_trk_t                ex_r;
    ex_trk_t                ex_s;
    mem_trk_t               mem_r;
    mem_trk_t               mem_s;
    logic                   ex_valid_r;
    logic                   mul_busy_r;
    logic                   mul_busy_s;

    logic                   dep_a_s;
    logic                   dep_b_s;
    logic [1:0]             fwd_a_s;
    logic [1:0]             fwd_b_s;
    logic                   load_use_s;
    logic                   flush_s;
    logic                   stall_s;
    logic                   accept_s;
    logic                   mul_enter_s;

    hazard_fwd_sel u_fwd_a (
        .src         (id_rs1),
        .ex_v        (ex_r.v),
        .ex_rd       (ex_r.rd),
        .ex_wr       (ex_r.wr),
        .ex_h0       (ex_r.h0),
        .mem_v       (mem_r.v),
        .mem_rd      (mem_r.rd),
        .mem_wr      (mem_r.wr),
        .fwd         (fwd_a_s),
        .ex_late_hit (dep_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .src         (id_rs2),
        .ex_v        (ex_r.v),
        .ex_rd       (ex_r.rd),
        .ex_wr       (ex_r.wr),
        .ex_h0       (ex_r.h0),
        .mem_v       (mem_r.v),
        .mem_rd      (mem_r.rd),
        .mem_wr      (mem_r.wr),
        .fwd         (fwd_b_s),
        .ex_late_hit (dep_b_s)
    );

    // FSM state and multiply counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: enter MUL when a multiply is accepted, leave when the
    // counter shows the last held cycle.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mul_enter_s) begin
                    state_s = ST_MUL;
                    cnt_s   = MUL_INIT;
                end else begin
                    state_s = ST_RUN;
                    cnt_s   = cnt_r;
                end
            end
            ST_MUL: begin
                cnt_s = cnt_r - {{(MUL_CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == {{(MUL_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = '0;
            end
        endcase
    end

    // Control outputs: interlock, flush and whether ID advances into EX.
    // A redirect squashes ID, so it also cancels any load-use stall.
    always_comb begin
        load_use_s = 1'b0;
        flush_s    = 1'b0;
        stall_s    = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                flush_s    = ex_redirect;
                load_use_s = id_valid & ((id_use_rs1 & dep_a_s) |
                                         (id_use_rs2 & dep_b_s));
                stall_s    = load_use_s & ~flush_s;
                accept_s   = id_valid & ~load_use_s & ~flush_s;
            end
            ST_MUL: begin
                stall_s = 1'b1;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
        mul_enter_s = accept_s & id_is_multiply;
    end

    // Next tracking contents: advance EX->MEM and ID->EX in RUN, hold in MUL.
    always_comb begin
        ex_s  = ex_r;
        mem_s = mem_r;
        if (state_r == ST_RUN) begin
            mem_s.v  = ex_r.v;
            mem_s.rd = ex_r.rd;
            mem_s.wr = ex_r.wr;
            ex_s.v   = accept_s;
            ex_s.rd  = id_rd;
            ex_s.wr  = id_reg_write;
            ex_s.h0  = id_is_hazard_0;
            ex_s.mul = id_is_multiply & accept_s;
        end else begin
            ex_s  = ex_r;
            mem_s = mem_r;
        end
        mul_busy_s = (state_s == ST_MUL) & ex_s.mul;
    end

    // Pipeline tracking registers and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_r       <= '0;
            mem_r      <= '0;
            ex_valid_r <= 1'b0;
            mul_busy_r <= 1'b0;
        end else begin
            ex_r       <= ex_s;
            mem_r      <= mem_s;
            ex_valid_r <= ex_s.v;
            mul_busy_r <= mul_busy_s;
        end
    end

    // Flush is forced low while reset is held, whatever EX reports.
    assign flush    = flush_s & rstn;
    assign stall    = stall_s;
    assign fwd_a    = fwd_a_s;
    assign fwd_b    = fwd_b_s;
    assign ex_valid = ex_valid_r;
    assign mul_busy = mul_busy_r;

endmodule
